// File: rtl/csr_access_unit.sv
// csr_access_unit
// Issue-side CSR execution stage. It accepts CSRRW/CSRRS/CSRRC requests,
// including the immediate forms, from dispatch. It reads the per-core CSR
// store through a combinational port, writes the read-modify-write result
// through a synchronous port, and returns the old CSR value to commit through
// a single registered valid/ready slot.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_*                 dispatch request (valid/ready handshake)
//   fpu_pending           per-warp "FPU ops in flight"; stalls FP CSR accesses
//   csr_read_*            combinational read port of the CSR store
//   csr_write_*           synchronous write port of the CSR store
//   rsp_*                 registered response to commit (valid/ready handshake)
//   busy                  unit has a request presented or a response held
module csr_access_unit #(
   parameter int NUM_WARPS     = 4,
   parameter int NUM_THREADS   = 4,
   parameter int NW_BITS       = 2,
   parameter int CSR_ADDR_BITS = 12,
   parameter int CSR_WIDTH     = 12
) (
   input  logic                       clk,
   input  logic                       reset,

   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [NW_BITS-1:0]         req_wid,
   input  logic [NUM_THREADS-1:0]     req_tmask,
   input  logic [31:0]                req_pc,
   input  logic [4:0]                 req_rd,
   input  logic                       req_wb,
   input  logic [1:0]                 req_op,
   input  logic                       req_use_imm,
   input  logic [4:0]                 req_imm,
   input  logic [NUM_THREADS*32-1:0]  req_rs1_data,
   input  logic [CSR_ADDR_BITS-1:0]   req_addr,

   input  logic [NUM_WARPS-1:0]       fpu_pending,

   output logic                       csr_read_enable,
   output logic [CSR_ADDR_BITS-1:0]   csr_read_addr,
   output logic [NW_BITS-1:0]         csr_read_wid,
   input  logic [31:0]                csr_read_data,

   output logic                       csr_write_enable,
   output logic [CSR_ADDR_BITS-1:0]   csr_write_addr,
   output logic [NW_BITS-1:0]         csr_write_wid,
   output logic [CSR_WIDTH-1:0]       csr_write_data,

   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [NW_BITS-1:0]         rsp_wid,
   output logic [NUM_THREADS-1:0]     rsp_tmask,
   output logic [31:0]                rsp_pc,
   output logic [4:0]                 rsp_rd,
   output logic                       rsp_wb,
   output logic [NUM_THREADS*32-1:0]  rsp_data,

   output logic                       busy
);

   localparam logic [CSR_ADDR_BITS-1:0] ADDR_FFLAGS = CSR_ADDR_BITS'(12'h001);
   localparam logic [CSR_ADDR_BITS-1:0] ADDR_FRM    = CSR_ADDR_BITS'(12'h002);
   localparam logic [CSR_ADDR_BITS-1:0] ADDR_FCSR   = CSR_ADDR_BITS'(12'h003);

   localparam logic [1:0] OP_RW = 2'd0;
   localparam logic [1:0] OP_RS = 2'd1;
   localparam logic [1:0] OP_RC = 2'd2;

   logic [31:0]          src;
   logic [31:0]          old_val;
   logic [CSR_WIDTH-1:0] new_val;
   logic                 fp_csr;
   logic                 stall_fp;
   logic                 fire;

   // Source operand: the rs1 value of the lowest active lane. Scanning from
   // the top down lets the lowest set bit win. An empty mask falls back to
   // lane 0.
   always_comb begin
      src = req_rs1_data[31:0];
      for (int i = NUM_THREADS - 1; i >= 0; i--) begin
         if (req_tmask[i]) begin
            src = req_rs1_data[i*32 +: 32];
         end
      end
      if (req_use_imm) begin
         src = {27'd0, req_imm};
      end
   end

   assign fp_csr   = (req_addr == ADDR_FFLAGS) | (req_addr == ADDR_FRM) | (req_addr == ADDR_FCSR);
   assign stall_fp = fp_csr & fpu_pending[req_wid];

   assign req_ready = ~reset & ~stall_fp & (~rsp_valid | rsp_ready);
   assign fire      = req_valid & req_ready;

   assign csr_read_enable = fire;
   assign csr_read_addr   = req_addr;
   assign csr_read_wid    = req_wid;
   assign old_val         = csr_read_data;

   // Illegal op 3 falls into the default arm and behaves like RW.
   always_comb begin
      case (req_op)
         OP_RS:   new_val = old_val[CSR_WIDTH-1:0] | src[CSR_WIDTH-1:0];
         OP_RC:   new_val = old_val[CSR_WIDTH-1:0] & ~src[CSR_WIDTH-1:0];
         default: new_val = src[CSR_WIDTH-1:0];
      endcase
   end

   // RS/RC with a zero source are pure reads and leave the store untouched.
   // Op 3 counts as RW here as well.
   assign csr_write_enable = fire & ((req_op == OP_RW) | (req_op == 2'd3) | (src != 32'd0));
   assign csr_write_addr   = req_addr;
   assign csr_write_wid    = req_wid;
   assign csr_write_data   = new_val;

   assign busy = req_valid | rsp_valid;

   // Single response slot. A fire in the same cycle as a drain reloads the
   // slot and keeps rsp_valid high, so the unit sustains one op per cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_wid   <= '0;
         rsp_tmask <= '0;
         rsp_pc    <= '0;
         rsp_rd    <= '0;
         rsp_wb    <= 1'b0;
         rsp_data  <= '0;
      end else if (fire) begin
         rsp_valid <= 1'b1;
         rsp_wid   <= req_wid;
         rsp_tmask <= req_tmask;
         rsp_pc    <= req_pc;
         rsp_rd    <= req_rd;
         rsp_wb    <= req_wb;
         rsp_data  <= {NUM_THREADS{old_val}};
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (!reset && fire) begin
         assert (req_op != 2'd3)
            else $error("csr_access_unit: illegal CSR op 3 accepted");
      end
   end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Issue-side CSR execution stage. Accepts CSR instructions (CSRRW/CSRRS/CSRRC and their immediate forms) from the dispatch stage.
- Drives the combinational read and synchronous write ports of the per-core CSR data store.
- Computes the read-modify-write value and returns the old CSR value to the commit stage through a registered valid/ready output.
- Stalls FP CSR accesses while the issuing warp has FPU operations in flight.

Parameters:
NUM_WARPS, 4, warps per core
NUM_THREADS, 4, threads per warp
NW_BITS, 2, warp-id width (clog2(NUM_WARPS), min 1)
CSR_ADDR_BITS, 12, CSR address width
CSR_WIDTH, 12, width of CSR write data

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_wid  in  NW_BITS  issuing warp
req_tmask  in  NUM_THREADS  active thread mask
req_pc  in  32  instruction PC
req_rd  in  5  destination register
req_wb  in  1  write-back enable
req_op  in  2  0=RW, 1=RS, 2=RC; 3 is illegal
req_use_imm  in  1  source is the zero-extended 5-bit immediate
req_imm  in  5  immediate (uimm)
req_rs1_data  in  NUM_THREADS*32  rs1 value per thread
req_addr  in  CSR_ADDR_BITS  CSR address
fpu_pending  in  NUM_WARPS  per-warp FPU ops outstanding
csr_read_enable  out  1  read strobe
csr_read_addr  out  CSR_ADDR_BITS  read address
csr_read_wid  out  NW_BITS  read warp
csr_read_data  in  32  combinational read result
csr_write_enable  out  1  write strobe
csr_write_addr  out  CSR_ADDR_BITS  write address
csr_write_wid  out  NW_BITS  write warp
csr_write_data  out  CSR_WIDTH  write value
rsp_valid  out  1  result valid to commit
rsp_ready  in  1  commit accepts
rsp_wid  out  NW_BITS  result warp
rsp_tmask  out  NUM_THREADS  result mask
rsp_pc  out  32  result PC
rsp_rd  out  5  result rd
rsp_wb  out  1  result write-back
rsp_data  out  NUM_THREADS*32  old CSR value, replicated to all lanes
busy  out  1  unit holds work

Behaviour:
- Reset: rsp_valid=0, busy=0. All rsp_* payload registers are cleared to 0. csr_read_enable and csr_write_enable are 0 during reset.
- Source operand: src = req_use_imm ? zero-extend(req_imm) : rs1 lane of the lowest set bit of req_tmask. If req_tmask=0, lane 0 is used.
- FP hazard:
  - fp_csr = req_addr in {FFLAGS 0x001, FRM 0x002, FCSR 0x003}.
  - stall_fp = fp_csr & fpu_pending[req_wid].
- Handshake: req_ready = ~reset & ~stall_fp & (~rsp_valid | rsp_ready). fire = req_valid & req_ready.
- Read port:
  - csr_read_enable = fire; csr_read_addr = req_addr; csr_read_wid = req_wid. All combinational.
  - old = csr_read_data, sampled in the same cycle as fire.
- Write value: RW → src; RS → old | src; RC → old & ~src. csr_write_data is the low CSR_WIDTH bits of the result.
- Write enable:
  - csr_write_enable = fire & (op==RW | src!=0).
  - RS/RC with src==0 perform no write (read-only access).
  - Address/wid equal the request's. The store updates on the same clk edge as fire.
- Ordering: a request firing in cycle N+1 reads the value written in cycle N. No bypass is needed.
- Response:
  - On fire, the response registers load wid/tmask/pc/rd/wb and data={NUM_THREADS{old}}, and rsp_valid is set the next cycle. Latency is 1 cycle.
  - rsp_valid is cleared on rsp_valid&rsp_ready&~fire.
  - Simultaneous drain and fire: the registers reload and rsp_valid stays 1 (full throughput).
- Backpressure: while rsp_valid & ~rsp_ready, req_ready=0. The response payload is held stable.
- Illegal op 3: treated as RW for the datapath; the simulation assertion fires on fire.
- busy = req_valid | rsp_valid.
- Reset mid-operation: a pending response is dropped and no write issues during reset.
- fpu_pending changes only affect req_ready combinationally. A request held with a stable payload fires in the first cycle its warp's pending bit is 0.

Test Plan:
- RW, x-data 0x5A, addr MSCRATCH-like reg (0x340) holding 0x123 → write_enable=1 with data 0x05A; rsp_data lanes=0x123 one cycle later.
- RS imm=0 on 0x340 → write_enable=0; rsp_data=current value. RC src=0x00F on a value of 0x0FF → writes 0x0F0.
- Back-to-back RW 0x11 then read (RS src 0) of the same addr/wid → second rsp_data=0x11.
- FRM write for warp 2 with fpu_pending=4'b0100 for 5 cycles → req_ready=0 for 5 cycles, then fires. The same access for warp 1 fires immediately.
- rsp_ready=0 for 3 cycles with two queued requests → req_ready=0, rsp payload stable; when rsp_ready returns, drain and next fire occur in the same cycle.
- Assert reset while rsp_valid=1 → rsp_valid=0 next cycle; no csr_write_enable during reset.
